isp_ae_dgain_ctrl: RTL and testbench

- Closed-loop auto-exposure controller that drives the digital-gain stage's AE feedback gain-table index.
- Accumulates raw-pixel brightness over each frame and compares the frame mean against a programmable target window using a sequential multiplier (no divider).
- Steps the gain index up or down once per decision frame, clamped to the table range.
- Sits beside the digital-gain stage, tapping the same in_href/in_vsync/in_raw stream; its ae_index output feeds that stage's AE feedback index input.

---
 rtl/isp_ae_dgain_ctrl.sv | 135 +++++++++++++
 tb/tb_isp_ae_dgain_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/isp_ae_dgain_ctrl.sv
// isp_ae_dgain_ctrl: closed-loop AE controller stepping the digital-gain table index from frame mean brightness.
// Optional ISP_AE_FAST_STEP_EN: step by 4 when the mean is far outside the target window.
module isp_ae_dgain_ctrl #(
  parameter int BITS = 8,
  parameter int WIDTH = 1280,
  parameter int HEIGHT = 960,
  parameter int DGAIN_ARRAY_SIZE = 100,
  parameter int DGAIN_ARRAY_BITS = $clog2(DGAIN_ARRAY_SIZE),
  parameter int CNT_BITS = $clog2(WIDTH*HEIGHT+1),
  parameter int SUM_BITS = BITS+CNT_BITS
) (
  input  logic                        pclk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [DGAIN_ARRAY_BITS-1:0] init_index,
  input  logic [BITS-1:0]             target_lo,
  input  logic [BITS-1:0]             target_hi,
  input  logic [3:0]                  skip_frames,
  input  logic                        in_href,
  input  logic                        in_vsync,
  input  logic [BITS-1:0]             in_raw,
  output logic [DGAIN_ARRAY_BITS-1:0] ae_index,
  output logic                        index_valid,
  output logic                        converged,
  output logic                        busy
);
  typedef enum logic [1:0] {IDLE, MUL, DECIDE} state_t;
  localparam logic [DGAIN_ARRAY_BITS-1:0] MAX_IDX = DGAIN_ARRAY_BITS'(DGAIN_ARRAY_SIZE-1);
  localparam int BC = $clog2(BITS+1);
  state_t state_q;
  logic vsync_q, frame_edge, start, valid_q, conv_q;
  logic [SUM_BITS-1:0] sum_q, sum_d, s_q, lo_q, hi_q, mcand_q;
  logic [SUM_BITS:0] sum_add;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS:0] cnt_add;
  logic [3:0] skip_q, skip_d;
  logic [BITS-1:0] tlo_q, thi_q;
  logic [BC-1:0] bit_q;
  logic [DGAIN_ARRAY_BITS-1:0] idx_q, init_clamp, up_idx, dn_idx;
  logic [DGAIN_ARRAY_BITS:0] up_sum;
  logic [2:0] step_up, step_dn;
  assign frame_edge = in_vsync & ~vsync_q;
  assign init_clamp = (init_index > MAX_IDX) ? MAX_IDX : init_index;
  assign start = frame_edge && enable && state_q == IDLE && cnt_q != '0 && skip_q == skip_frames;
`ifdef ISP_AE_FAST_STEP_EN
  assign step_up = (s_q < (lo_q >> 1)) ? 3'd4 : 3'd1;
  assign step_dn = ({1'b0, s_q} > ({1'b0, hi_q} + {2'b0, hi_q[SUM_BITS-1:1]})) ? 3'd4 : 3'd1;
`else
  assign step_up = 3'd1;
  assign step_dn = 3'd1;
`endif
  always_comb begin
    sum_add = {1'b0, sum_q} + (SUM_BITS+1)'(in_raw);
    cnt_add = {1'b0, cnt_q} + (CNT_BITS+1)'(1);
    sum_d = frame_edge ? (in_href ? SUM_BITS'(in_raw) : '0) :
            !in_href ? sum_q : sum_add[SUM_BITS] ? '1 : sum_add[SUM_BITS-1:0];
    cnt_d = frame_edge ? CNT_BITS'(in_href) :
            !in_href ? cnt_q : cnt_add[CNT_BITS] ? '1 : cnt_add[CNT_BITS-1:0];
    // a frame that matches but cannot start still restarts the skip period
    skip_d = !frame_edge ? skip_q : (start || skip_q >= skip_frames) ? 4'd0 : skip_q + 4'd1;
    up_sum = {1'b0, idx_q} + (DGAIN_ARRAY_BITS+1)'(step_up);
    up_idx = (up_sum >= {1'b0, MAX_IDX}) ? MAX_IDX : up_sum[DGAIN_ARRAY_BITS-1:0];
    dn_idx = (idx_q < DGAIN_ARRAY_BITS'(step_dn)) ? '0 : idx_q - DGAIN_ARRAY_BITS'(step_dn);
  end
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      sum_q <= '0;
      cnt_q <= '0;
      s_q <= '0;
      skip_q <= '0;
    end else begin
      vsync_q <= in_vsync;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      skip_q <= skip_d;
      if (frame_edge) s_q <= sum_q;
    end
  end
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= init_clamp;
      valid_q <= 1'b0;
      conv_q <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
      mcand_q <= '0;
      tlo_q <= '0;
      thi_q <= '0;
      bit_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (!enable) begin
        state_q <= IDLE;
        idx_q <= init_clamp;
        conv_q <= 1'b0;
      end else if (state_q == MUL) begin
        if (frame_edge) state_q <= IDLE;
        else begin
          // one multiplier bit per cycle for both window bounds
          lo_q <= tlo_q[0] ? lo_q + mcand_q : lo_q;
          hi_q <= thi_q[0] ? hi_q + mcand_q : hi_q;
          mcand_q <= mcand_q << 1;
          tlo_q <= tlo_q >> 1;
          thi_q <= thi_q >> 1;
          bit_q <= bit_q + 1'b1;
          if (bit_q == BC'(BITS-1)) state_q <= DECIDE;
        end
      end else if (state_q == DECIDE) begin
        state_q <= IDLE;
        valid_q <= 1'b1;
        if (s_q < lo_q) begin
          idx_q <= up_idx;
          conv_q <= 1'b0;
        end else if (s_q > hi_q) begin
          idx_q <= dn_idx;
          conv_q <= 1'b0;
        end else conv_q <= 1'b1;
      end else if (start) begin
        state_q <= MUL;
        lo_q <= '0;
        hi_q <= '0;
        mcand_q <= SUM_BITS'(cnt_q);
        tlo_q <= target_lo;
        thi_q <= target_hi;
        bit_q <= '0;
      end
    end
  end
  assign ae_index = idx_q;
  assign index_valid = valid_q;
  assign converged = conv_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_isp_ae_dgain_ctrl.sv
// tb_isp_ae_dgain_ctrl: randomized frames checked against a frame-level mean/window reference model.
module tb_isp_ae_dgain_ctrl;
  localparam int BITS = 8;
  localparam int SIZE = 100;
  localparam int CMAX = 15;
  localparam int SMAX = 4095;
`ifdef ISP_AE_FAST_STEP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic pclk = 1'b0, rst_n = 1'b0, enable = 1'b1, in_href = 1'b0, in_vsync = 1'b0;
  logic [6:0] init_index = '0;
  logic [7:0] target_lo = 8'd100, target_hi = 8'd120, in_raw = '0;
  logic [3:0] skip_frames = '0;
  logic [6:0] ae_index;
  logic index_valid, converged, busy;
  int total = 0, bad = 0;
  int idx_m, conv_m, fno, skip_m;
  always #5 pclk = ~pclk;
  isp_ae_dgain_ctrl #(.BITS(BITS), .WIDTH(4), .HEIGHT(2), .DGAIN_ARRAY_SIZE(SIZE)) dut (
    .pclk(pclk), .rst_n(rst_n), .enable(enable), .init_index(init_index),
    .target_lo(target_lo), .target_hi(target_hi), .skip_frames(skip_frames),
    .in_href(in_href), .in_vsync(in_vsync), .in_raw(in_raw),
    .ae_index(ae_index), .index_valid(index_valid), .converged(converged), .busy(busy));
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic do_reset(input int init, input int skip);
    rst_n = 1'b0;
    enable = 1'b1;
    init_index = 7'(init);
    skip_frames = 4'(skip);
    in_href = 1'b0;
    in_vsync = 1'b0;
    tick();
    chk("rst_idx", ae_index, init > SIZE-1 ? SIZE-1 : init);
    chk("rst_valid", index_valid, 0);
    chk("rst_conv", converged, 0);
    chk("rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    idx_m = init > SIZE-1 ? SIZE-1 : init;
    conv_m = 0;
    fno = 0;
    skip_m = skip;
  endtask
  task automatic pixels(input int npix, input int vmin, input int vmax, output int s, output int c);
    s = 0;
    c = 0;
    for (int i = 0; i < npix; i++) begin
      in_href = 1'b1;
      in_raw = 8'($urandom_range(vmax, vmin));
      s += int'(in_raw);
      c++;
      tick();
      in_href = 1'b0;
      if ($urandom_range(1, 0) == 1) tick();
    end
  endtask
  // reference: decide on frames whose 0-based number is skip mod (skip+1), compare mean with window
  task automatic model(input int s_raw, input int c_raw, output bit dec);
    int s, c, lo, hi, st;
    s = s_raw > SMAX ? SMAX : s_raw;
    c = c_raw > CMAX ? CMAX : c_raw;
    lo = int'(target_lo) * c;
    hi = int'(target_hi) * c;
    dec = c != 0 && (fno % (skip_m + 1)) == skip_m;
    fno++;
    if (dec) begin
      if (s < lo) begin
        st = (FAST && s < lo / 2) ? 4 : 1;
        idx_m = idx_m + st > SIZE-1 ? SIZE-1 : idx_m + st;
        conv_m = 0;
      end else if (s > hi) begin
        st = (FAST && s > hi + hi / 2) ? 4 : 1;
        idx_m = idx_m - st < 0 ? 0 : idx_m - st;
        conv_m = 0;
      end else conv_m = 1;
    end
  endtask
  task automatic frame(input int npix, input int vmin, input int vmax);
    int s, c, old, pulses, vcyc;
    bit dec;
    in_vsync = 1'b0;
    tick();
    pixels(npix, vmin, vmax, s, c);
    old = idx_m;
    model(s, c, dec);
    in_vsync = 1'b1;
    pulses = 0;
    vcyc = 0;
    for (int k = 1; k <= BITS + 4; k++) begin
      tick();
      if (index_valid) begin
        pulses++;
        vcyc = k;
      end
      if (k == 4) chk("busy_mul", busy, int'(dec));
      if (k == BITS + 1) chk("idx_before", ae_index, old);
    end
    chk("pulses", pulses, int'(dec));
    if (dec) chk("latency", vcyc, BITS + 2);
    chk("idx", ae_index, idx_m);
    chk("conv", converged, conv_m);
  endtask
  initial begin
    int s, c, pulses;
    bit dec;
    do_reset(5, 0);
    frame(8, 10, 10);
    frame(8, 110, 110);
    frame(8, 200, 220);
    do_reset(0, 0);
    frame(8, 255, 255);
    do_reset(10, 0);
    frame(8, 255, 255);
    do_reset(120, 0);
    frame(8, 0, 5);
    do_reset(5, 2);
    for (int f = 0; f < 6; f++) frame(8, 10, 10);
    // vsync re-rises while the multiply is running
    do_reset(5, 0);
    in_vsync = 1'b0;
    tick();
    pixels(8, 10, 10, s, c);
    model(s, c, dec);
    idx_m = 5;
    conv_m = 0;
    in_vsync = 1'b1;
    tick();
    tick();
    in_vsync = 1'b0;
    tick();
    tick();
    in_vsync = 1'b1;
    model(0, 0, dec);
    pulses = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (index_valid) pulses++;
    end
    chk("abort_pulses", pulses, 0);
    chk("abort_idx", ae_index, 5);
    frame(8, 10, 10);
    frame(0, 0, 0);
    // enable dropped mid-multiply
    in_vsync = 1'b0;
    tick();
    pixels(8, 10, 10, s, c);
    in_vsync = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("en_busy", busy, 1);
    enable = 1'b0;
    init_index = 7'd20;
    tick();
    chk("en_idx", ae_index, 20);
    chk("en_busy_off", busy, 0);
    chk("en_conv", converged, 0);
    enable = 1'b1;
    idx_m = 20;
    conv_m = 0;
    fno++;
    frame(8, 10, 10);
    // reset mid-multiply with pixels already accumulated
    in_vsync = 1'b0;
    tick();
    pixels(6, 10, 10, s, c);
    in_vsync = 1'b1;
    tick();
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      in_href = 1'b1;
      in_raw = 8'd255;
      tick();
    end
    do_reset(40, 0);
    frame(2, 0, 0);
    for (int seg = 0; seg < 4; seg++) begin
      do_reset($urandom_range(127, 0), $urandom_range(3, 0));
      for (int f = 0; f < 10; f++) begin
        int lo, hi, vmin, vmax;
        lo = $urandom_range(200, 0);
        hi = $urandom_range(255, lo);
        target_lo = 8'(lo);
        target_hi = 8'(hi);
        vmin = $urandom_range(255, 0);
        vmax = $urandom_range(255, vmin);
        frame($urandom_range(8, 1), vmin, vmax);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
